data_mem_responder: RTL

//  Data-memory responder at the far end of the core's load/store port. Accepts one

---
 rtl/data_mem_responder_pkg.sv | 34 +++
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder_bytewise_ram.sv | 25 ++
 rtl/data_mem_responder.sv | 99 +++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared state type, write-mask constants and mask/alignment check
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [3:0] MASK_READ = 4'b0000;
  localparam logic [3:0] MASK_B0   = 4'b0001;
  localparam logic [3:0] MASK_B1   = 4'b0010;
  localparam logic [3:0] MASK_B2   = 4'b0100;
  localparam logic [3:0] MASK_B3   = 4'b1000;
  localparam logic [3:0] MASK_H0   = 4'b0011;
  localparam logic [3:0] MASK_H1   = 4'b1100;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // Reads ignore the low address bits; writes must sit on the lanes the address selects.
  function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] addr_lo);
    case (mask)
      MASK_READ: return 1'b1;
      MASK_B0:   return addr_lo == 2'b00;
      MASK_B1:   return addr_lo == 2'b01;
      MASK_B2:   return addr_lo == 2'b10;
      MASK_B3:   return addr_lo == 2'b11;
      MASK_H0:   return addr_lo == 2'b00;
      MASK_H1:   return addr_lo == 2'b10;
      MASK_W:    return addr_lo == 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and response bundle
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_bytewise_ram.sv
// rtl/data_mem_responder_bytewise_ram.sv - single-port word RAM with byte write enables and registered read
module bytewise_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - one-at-a-time data-memory responder with wait states and range/mask checking
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  mem_state_t  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic        rd_ok_q;

  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_mask;
  logic [29:0] word_off;
  logic        err_now;
  logic        accept;
  logic        commit;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  // In IDLE the live request feeds the RAM so a zero-wait build can commit on the accept edge.
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign cur_mask  = (state == IDLE) ? bus.req_wmask : mask_q;

  // BASE_ADDR is word aligned, so the word offset is a difference of the upper bits (wraps below base).
  assign word_off = cur_addr[31:2] - BASE_ADDR[31:2];
  assign err_now  = (word_off >= 30'(DEPTH_WORDS)) || !mask_legal(cur_mask, cur_addr[1:0]);

  assign accept = bus.req_valid && bus.req_ready;
  assign commit = reset && (((state == IDLE) && bus.req_valid && ZERO_WAIT) ||
                            ((state == WAIT) && (cnt == 4'd0)));
  assign ram_we = (commit && !err_now) ? cur_mask : 4'b0000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      rsp_valid_q <= commit;
      rsp_err_q   <= commit && err_now;
      rd_ok_q     <= commit && !err_now && (cur_mask == MASK_READ);
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            mask_q  <= bus.req_wmask;
            if (ZERO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bytewise_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (commit),
    .we    (ram_we),
    .addr  (word_off[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready = reset && (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rd_ok_q ? ram_rdata : 32'h0;

endmodule
